id_queue_dp: RTL
================

ID_QUEUE_DP -- requirements
Module: id_queue_dp

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 2, width of element ID; legal >= 1.
REQ-002 SHALL have parameter CAPACITY, default 8, max stored elements regardless of ID; legal >= 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, element payload width; legal >= 1.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, synchronous, active-high; single clock domain.
REQ-005 SHALL have ports: inp_id_i in ID_WIDTH; inp_data_i in DATA_WIDTH; inp_req_i in 1; inp_gnt_o out 1 push handshake.
REQ-006 SHALL have ports: oup_id_i in ID_WIDTH; oup_pop_i in 1; oup_req_i in 1; oup_gnt_o out 1; oup_data_o out DATA_WIDTH; oup_data_valid_o out 1.
REQ-007 SHALL have ports: exists_data_i in DATA_WIDTH; exists_mask_i in DATA_WIDTH; exists_req_i in 1; exists_o out 1; exists_gnt_o out 1.
REQ-008 SHALL have ports: flush_i in 1 synchronous clear; count_o out $clog2(CAPACITY+1) total occupancy; full_o out 1; empty_o out 1.

Function
REQ-009 SHALL preserve FIFO order among elements of equal ID; no ordering between different IDs.
REQ-010 SHALL use a head-tail table of min(2**ID_WIDTH, CAPACITY) entries plus a linked data table of CAPACITY entries, each with free bit.
REQ-011 SHALL set inp_gnt_o = inp_req_i && !full_o, from registered state only; push does not depend on same-cycle pop.
REQ-012 SHALL grant oup_req_i every cycle (oup_gnt_o = oup_req_i), independent of push — push and pop both proceed in one cycle.
REQ-013 SHALL drive oup_data_o combinationally from head element of oup_id_i in registered state; oup_data_valid_o = oup_req_i && ID present.
REQ-014 SHALL dequeue head iff oup_req_i && oup_pop_i && oup_data_valid_o; non-pop request is non-destructive read.
REQ-015 SHALL allocate pushed element to lowest free data index and, for new ID, lowest free head-tail index; update takes effect next cycle.
REQ-016 Same-cycle push and pop, different IDs: SHALL apply both; count_o unchanged.
REQ-017 Same-cycle push and pop, same ID, ID holds >= 2 elements: head advances, tail becomes new element.
REQ-018 Same-cycle push and pop, same ID, ID holds exactly 1 element: head-tail entry SHALL stay allocated with head = tail = new element; old data slot freed.
REQ-019 Same-cycle push and pop when full: push SHALL NOT be granted; pop proceeds.
REQ-020 Element pushed in cycle N SHALL NOT be visible to oup_ or exists_ ports before cycle N+1.
REQ-021 Pop on absent ID SHALL change no state; oup_data_valid_o = 0; oup_data_o don't care.
REQ-022 exists_gnt_o = exists_req_i; exists_o = 1 iff any non-free entry matches exists_data_i on all bits set in exists_mask_i; combinational on registered state; 0 when exists_req_i = 0.
REQ-023 count_o SHALL be a registered counter: +1 on granted push, -1 on pop, unchanged on both; never exceeds CAPACITY or wraps below 0.
REQ-024 full_o = (count_o == CAPACITY); empty_o = (count_o == 0).
REQ-025 flush_i SHALL free all entries next cycle, overriding same-cycle push/pop; inp_gnt_o = 0 while flush_i asserted; oup_ read still reflects pre-flush state.

Reset
REQ-026 rst_i high at clock edge SHALL free all table entries; count_o = 0, empty_o = 1, full_o = 0 following edge.
REQ-027 During and after reset inp_gnt_o = 0 only while rst_i high; oup_data_valid_o = 0, exists_o = 0 after reset; reset mid-operation discards all contents.
REQ-028 Data payload and link fields SHALL need no reset; only free bits, counter reset.

Verification (CAPACITY=4, ID_WIDTH=2, DATA_WIDTH=8)
REQ-029 Push (id1,0xA1),(id1,0xA2),(id2,0xB1); read id1 without pop x2 -> 0xA1 both; pop id1, id2, id1 -> 0xA1, 0xB1, 0xA2; count 3->0.
REQ-030 Fill 4 elements -> full_o=1, inp_gnt_o=0 on 5th req; same cycle pop id0 -> oup_data_valid_o=1, count 3 next cycle, 5th push granted following cycle.
REQ-031 id3 holds single 0x30; same cycle push (id3,0x31) and pop id3 -> 0x30 returned; next cycle read id3 -> 0x31, count 1.
REQ-032 Store 0x5A, 0x3C; exists 0x5F mask 0xF0 -> 1; exists 0x0A mask 0xFF -> 0; pop 0x5A then exists 0x5F mask 0xF0 -> 0.
REQ-033 Pop absent id2 on empty queue -> oup_gnt_o=1, valid=0, count 0; flush with 3 stored -> count 0, empty_o=1, reads invalid.
REQ-034 Assert rst_i mid-stream with 2 elements -> count_o=0, empty_o=1 next cycle; prior IDs read invalid.

Source files
------------

// File: rtl/id_queue_dp.sv
// Multi-ID queue: each ID has its own FIFO. All IDs share one linked data table,
// and a small head-tail table maps each live ID to its list.
module id_queue_dp #(
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned CAPACITY   = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [ID_WIDTH-1:0]           inp_id_i,
    input  logic [DATA_WIDTH-1:0]         inp_data_i,
    input  logic                          inp_req_i,
    output logic                          inp_gnt_o,
    input  logic [ID_WIDTH-1:0]           oup_id_i,
    input  logic                          oup_pop_i,
    input  logic                          oup_req_i,
    output logic                          oup_gnt_o,
    output logic [DATA_WIDTH-1:0]         oup_data_o,
    output logic                          oup_data_valid_o,
    input  logic [DATA_WIDTH-1:0]         exists_data_i,
    input  logic [DATA_WIDTH-1:0]         exists_mask_i,
    input  logic                          exists_req_i,
    output logic                          exists_o,
    output logic                          exists_gnt_o,
    input  logic                          flush_i,
    output logic [$clog2(CAPACITY+1)-1:0] count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int unsigned NumIds = 2 ** ID_WIDTH;
    localparam int unsigned NumHt  = (NumIds < CAPACITY) ? NumIds : CAPACITY;
    localparam int unsigned IdxW   = $clog2(CAPACITY);
    localparam int unsigned HtW    = $clog2(NumHt);
    localparam int unsigned CntW   = $clog2(CAPACITY + 1);

    // Head-tail table
    logic [NumHt-1:0]    ht_free_q;
    logic [ID_WIDTH-1:0] ht_id_q   [NumHt];
    logic [IdxW-1:0]     ht_head_q [NumHt];
    logic [IdxW-1:0]     ht_tail_q [NumHt];

    // Linked data table
    logic [CAPACITY-1:0]   d_free_q;
    logic [DATA_WIDTH-1:0] d_data_q [CAPACITY];
    logic [IdxW-1:0]       d_next_q [CAPACITY];

    logic [CntW-1:0] count_q;

    logic            oup_hit, inp_hit;
    logic [HtW-1:0]  oup_ht, inp_ht, ht_free_idx;
    logic [IdxW-1:0] free_idx, pop_head;
    logic            pop_single, keep_entry;
    logic            push, pop;

    always_comb begin
        oup_hit = 1'b0;
        oup_ht  = '0;
        inp_hit = 1'b0;
        inp_ht  = '0;
        for (int unsigned i = 0; i < NumHt; i++) begin
            if (!ht_free_q[i] && ht_id_q[i] == oup_id_i) begin
                oup_hit = 1'b1;
                oup_ht  = HtW'(i);
            end
            if (!ht_free_q[i] && ht_id_q[i] == inp_id_i) begin
                inp_hit = 1'b1;
                inp_ht  = HtW'(i);
            end
        end
    end

    // Descending scans so the last match wins, giving the lowest free index.
    always_comb begin
        free_idx = '0;
        for (int i = int'(CAPACITY) - 1; i >= 0; i--) begin
            if (d_free_q[i]) free_idx = IdxW'(i);
        end
        ht_free_idx = '0;
        for (int i = int'(NumHt) - 1; i >= 0; i--) begin
            if (ht_free_q[i]) ht_free_idx = HtW'(i);
        end
    end

    always_comb begin
        exists_o = 1'b0;
        for (int unsigned i = 0; i < CAPACITY; i++) begin
            if (exists_req_i && !d_free_q[i] &&
                ((d_data_q[i] ^ exists_data_i) & exists_mask_i) == '0) begin
                exists_o = 1'b1;
            end
        end
    end

    assign count_o          = count_q;
    assign full_o           = (count_q == CntW'(CAPACITY));
    assign empty_o          = (count_q == '0);
    assign inp_gnt_o        = inp_req_i && !full_o && !flush_i && !rst_i;
    assign oup_gnt_o        = oup_req_i;
    assign oup_data_valid_o = oup_req_i && oup_hit;
    assign oup_data_o       = d_data_q[ht_head_q[oup_ht]];
    assign exists_gnt_o     = exists_req_i;

    assign push       = inp_gnt_o;
    assign pop        = oup_req_i && oup_pop_i && oup_data_valid_o && !flush_i && !rst_i;
    assign pop_head   = ht_head_q[oup_ht];
    assign pop_single = (pop_head == ht_tail_q[oup_ht]);
    // Push and pop of a single-element ID reuse the same head-tail entry.
    assign keep_entry = push && inp_hit && (inp_ht == oup_ht);

    // Payload and link fields carry no reset; only free bits qualify them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            d_data_q[free_idx] <= inp_data_i;
            if (inp_hit) begin
                d_next_q[ht_tail_q[inp_ht]] <= free_idx;
                ht_tail_q[inp_ht]           <= free_idx;
            end else begin
                ht_id_q[ht_free_idx]   <= inp_id_i;
                ht_head_q[ht_free_idx] <= free_idx;
                ht_tail_q[ht_free_idx] <= free_idx;
            end
        end
        if (pop) begin
            if (keep_entry && pop_single) begin
                ht_head_q[oup_ht] <= free_idx;
            end else if (!pop_single) begin
                ht_head_q[oup_ht] <= d_next_q[pop_head];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            d_free_q  <= '1;
            ht_free_q <= '1;
            count_q   <= '0;
        end else begin
            if (pop) begin
                d_free_q[pop_head] <= 1'b1;
                if (pop_single && !keep_entry) ht_free_q[oup_ht] <= 1'b1;
            end
            if (push) begin
                d_free_q[free_idx] <= 1'b0;
                if (!inp_hit) ht_free_q[ht_free_idx] <= 1'b0;
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule
